loas_score_accumulator: RTL and testbench

- Downstream consumer of the LOAS inner-join match stream: accepts (neuron, col, score) hits over valid/ready and accumulates match scores per neuron across one time window.
- On a window-done pulse it drains every non-zero per-neuron sum, in ascending neuron order, over a second valid/ready channel to the LIF update stage, then clears the sums for the next window.
- Decouples the bursty join output from the per-neuron membrane update.

---
 rtl/loas_score_accumulator.sv | 135 +++++++++++++
 tb/tb_loas_score_accumulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loas_score_accumulator.sv
// Per-neuron score accumulator between the LOAS join stream and the LIF update stage.
// Optional build macro LOAS_ACC_HITCOUNT_EN adds saturating per-neuron hit counters and out_hits.
//
// state   | meaning
// S_ACCUM | accept join hits, add scores into acc[]
// S_DRAIN | walk neuron ids 0..N-1, emit and clear non-empty entries
// S_FLUSH | let the last emitted entry drain, then pulse drain_done
module loas_score_accumulator #(
   parameter int T_WINDOW    = 16,
   parameter int NEURON_ID_W = 4,
   parameter int COL_ID_W    = 4,
   parameter int SCORE_W     = $clog2(T_WINDOW + 1),
   parameter int ACC_W       = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NEURON_ID_W-1:0] in_neuron,
   input  logic [COL_ID_W-1:0]    in_col,
   input  logic [SCORE_W-1:0]     in_score,
   input  logic                   window_done,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NEURON_ID_W-1:0] out_neuron,
   output logic [ACC_W-1:0]       out_sum,
`ifdef LOAS_ACC_HITCOUNT_EN
   output logic [COL_ID_W:0]      out_hits,
`endif
   output logic                   drain_done,
   output logic                   busy,
   output logic                   sat_flag
);

   localparam int N   = 2 ** NEURON_ID_W;
   localparam int AW1 = ACC_W + 1;
   localparam logic [ACC_W-1:0]       ACC_MAX  = '1;
   localparam logic [NEURON_ID_W-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_FLUSH} state_t;

   state_t                 state;
   logic [NEURON_ID_W-1:0] idx;
   logic [ACC_W-1:0]       acc [N];
   logic [ACC_W:0]         add_ext;
   logic [ACC_W-1:0]       add_sat;
   logic                   emit;
   logic                   out_free;

   // One extra bit catches the carry so the clamp never wraps.
   assign add_ext  = {1'b0, acc[in_neuron]} + AW1'(in_score);
   assign add_sat  = add_ext[ACC_W] ? ACC_MAX : add_ext[ACC_W-1:0];
   assign out_free = !out_valid || out_ready;
   assign in_ready = (state == S_ACCUM) && enable && !rst;
   assign busy     = (state != S_ACCUM);

`ifdef LOAS_ACC_HITCOUNT_EN
   localparam logic [COL_ID_W:0] HITS_MAX = '1;
   logic [COL_ID_W:0] hits [N];
   logic unused_col;
   assign unused_col = ^in_col;
   assign emit = (acc[idx] != '0) || (hits[idx] != '0);
`else
   logic unused_col;
   assign unused_col = ^in_col;
   assign emit = (acc[idx] != '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_ACCUM;
         idx        <= '0;
         out_valid  <= 1'b0;
         out_neuron <= '0;
         out_sum    <= '0;
         drain_done <= 1'b0;
         sat_flag   <= 1'b0;
         for (int i = 0; i < N; i++) acc[i] <= '0;
`ifdef LOAS_ACC_HITCOUNT_EN
         out_hits <= '0;
         for (int i = 0; i < N; i++) hits[i] <= '0;
`endif
      end else begin
         drain_done <= 1'b0;
         // Frozen, but a handshake already on the wire still retires.
         if (!enable && out_valid && out_ready) out_valid <= 1'b0;
         if (enable) begin
            case (state)
               S_ACCUM: begin
                  if (in_valid) begin
                     acc[in_neuron] <= add_sat;
                     if (add_ext[ACC_W]) sat_flag <= 1'b1;
`ifdef LOAS_ACC_HITCOUNT_EN
                     if (hits[in_neuron] != HITS_MAX)
                        hits[in_neuron] <= hits[in_neuron] + 1'b1;
`endif
                  end
                  if (window_done) begin
                     state <= S_DRAIN;
                     idx   <= '0;
                  end
               end
               S_DRAIN: begin
                  if (out_free) begin
                     if (emit) begin
                        out_valid  <= 1'b1;
                        out_neuron <= idx;
                        out_sum    <= acc[idx];
                        acc[idx]   <= '0;
`ifdef LOAS_ACC_HITCOUNT_EN
                        out_hits   <= hits[idx];
                        hits[idx]  <= '0;
`endif
                     end else begin
                        out_valid <= 1'b0;
                     end
                     idx <= idx + 1'b1;
                     if (idx == IDX_LAST) state <= S_FLUSH;
                  end
               end
               S_FLUSH: begin
                  if (out_free) begin
                     out_valid  <= 1'b0;
                     drain_done <= 1'b1;
                     state      <= S_ACCUM;
                  end
               end
               default: state <= S_ACCUM;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_loas_score_accumulator.sv
// Directed bench for loas_score_accumulator; a second instance with ACC_W=5 covers saturation.
module tb_loas_score_accumulator;

   logic       clk = 1'b0;
   logic       rst, enable, in_valid, window_done, out_ready;
   logic [3:0] in_neuron, in_col;
   logic [4:0] in_score;

   logic       in_ready, out_valid, drain_done, busy, sat_flag;
   logic [3:0] out_neuron;
   logic [9:0] out_sum;

   logic       in_ready_b, out_valid_b, drain_done_b, busy_b, sat_flag_b;
   logic [3:0] out_neuron_b;
   logic [4:0] out_sum_b;
`ifdef LOAS_ACC_HITCOUNT_EN
   logic [4:0] out_hits, out_hits_b;
`endif

   int total = 0;
   int bad   = 0;
   int got_n[$];
   int got_s[$];
   int got_sb[$];
   bit rdy_leak;
   int cyc;

   always #5 clk = ~clk;

   loas_score_accumulator dut (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .in_neuron(in_neuron), .in_col(in_col), .in_score(in_score), .window_done(window_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_neuron(out_neuron), .out_sum(out_sum),
`ifdef LOAS_ACC_HITCOUNT_EN
      .out_hits(out_hits),
`endif
      .drain_done(drain_done), .busy(busy), .sat_flag(sat_flag)
   );

   loas_score_accumulator #(.ACC_W(5)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_neuron(in_neuron), .in_col(in_col), .in_score(in_score), .window_done(window_done),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_neuron(out_neuron_b), .out_sum(out_sum_b),
`ifdef LOAS_ACC_HITCOUNT_EN
      .out_hits(out_hits_b),
`endif
      .drain_done(drain_done_b), .busy(busy_b), .sat_flag(sat_flag_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hit(input int n, input int s);
      in_valid  = 1'b1;
      in_neuron = 4'(n);
      in_score  = 5'(s);
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic pulse_done();
      window_done = 1'b1;
      tick();
      window_done = 1'b0;
   endtask

   // Runs until drain_done, recording every completed output handshake.
   task automatic drain_collect(output int cycles);
      got_n.delete();
      got_s.delete();
      got_sb.delete();
      rdy_leak = 1'b0;
      cycles   = 0;
      while (!drain_done && cycles < 200) begin
         if (in_ready) rdy_leak = 1'b1;
         if (out_valid && out_ready) begin
            got_n.push_back(int'(out_neuron));
            got_s.push_back(int'(out_sum));
         end
         if (out_valid_b && out_ready) got_sb.push_back(int'(out_sum_b));
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; window_done = 1'b0; out_ready = 1'b1;
      in_neuron = '0; in_col = '0; in_score = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
      total++; if (out_neuron !== 4'd0) begin bad++; $display("FAIL reset_out_neuron got=%0d exp=0", out_neuron); end
      total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
      total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done got=%0d exp=0", drain_done); end
      total++; if (sat_flag !== 1'b0 || sat_flag_b !== 1'b0) begin bad++; $display("FAIL reset_sat_flag got=%0d/%0d exp=0/0", sat_flag, sat_flag_b); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0d exp=1", in_ready); end
   endtask

   task automatic test_single_neuron();
      hit(3, 5); hit(3, 7); hit(3, 2);
      pulse_done();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0d exp=1", busy); end
      drain_collect(cyc);
      total++; if (got_n.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_n.size()); end
      else begin
         total++; if (got_n[0] !== 3 || got_s[0] !== 14) begin bad++; $display("FAIL single_entry got=%0d/%0d exp=3/14", got_n[0], got_s[0]); end
      end
      total++; if (cyc !== 17) begin bad++; $display("FAIL single_cycles got=%0d exp=17", cyc); end
      tick();
      total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%0d exp=0", drain_done); end
      pulse_done();
      drain_collect(cyc);
      total++; if (got_n.size() !== 0) begin bad++; $display("FAIL empty_count got=%0d exp=0", got_n.size()); end
      total++; if (cyc !== 17) begin bad++; $display("FAIL empty_cycles got=%0d exp=17", cyc); end
      tick();
   endtask

   task automatic test_order();
      hit(9, 4); hit(1, 6);
      pulse_done();
      drain_collect(cyc);
      total++; if (got_n.size() !== 2) begin bad++; $display("FAIL order_count got=%0d exp=2", got_n.size()); end
      else begin
         total++; if (got_n[0] !== 1 || got_s[0] !== 6) begin bad++; $display("FAIL order_first got=%0d/%0d exp=1/6", got_n[0], got_s[0]); end
         total++; if (got_n[1] !== 9 || got_s[1] !== 4) begin bad++; $display("FAIL order_second got=%0d/%0d exp=9/4", got_n[1], got_s[1]); end
      end
      total++; if (cyc !== 17) begin bad++; $display("FAIL order_cycles got=%0d exp=17", cyc); end
      tick();
   endtask

   task automatic test_same_cycle();
      in_valid = 1'b1; in_neuron = 4'd2; in_score = 5'd3; window_done = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL same_ready_before got=%0d exp=1", in_ready); end
      tick();
      in_valid = 1'b0; window_done = 1'b0;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL same_ready_after got=%0d exp=0", in_ready); end
      drain_collect(cyc);
      total++; if (rdy_leak !== 1'b0) begin bad++; $display("FAIL same_ready_leak got=%0d exp=0", rdy_leak); end
      total++; if (got_n.size() !== 1) begin bad++; $display("FAIL same_count got=%0d exp=1", got_n.size()); end
      else begin
         total++; if (got_n[0] !== 2 || got_s[0] !== 3) begin bad++; $display("FAIL same_entry got=%0d/%0d exp=2/3", got_n[0], got_s[0]); end
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL same_ready_done got=%0d exp=1", in_ready); end
      tick();
   endtask

   task automatic test_stall();
      int stalls = 0;
      int accepted = 0;
      bit unstable = 1'b0;
      hit(1, 6);
      out_ready = 1'b0;
      pulse_done();
      cyc = 0;
      while (!drain_done && cyc < 200) begin
         if (out_valid && !out_ready) begin
            if (out_neuron !== 4'd1 || out_sum !== 10'd6) unstable = 1'b1;
            if (stalls == 5) out_ready = 1'b1;
            else stalls++;
         end
         if (out_valid && out_ready) begin
            accepted++;
            if (out_neuron !== 4'd1 || out_sum !== 10'd6) unstable = 1'b1;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b1;
      total++; if (unstable !== 1'b0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
      total++; if (accepted !== 1) begin bad++; $display("FAIL stall_accepted got=%0d exp=1", accepted); end
      total++; if (cyc !== 22) begin bad++; $display("FAIL stall_cycles got=%0d exp=22", cyc); end
      tick();
   endtask

   task automatic test_saturation();
      hit(0, 16); hit(0, 16); hit(0, 16);
      pulse_done();
      drain_collect(cyc);
      total++; if (got_sb.size() !== 1) begin bad++; $display("FAIL sat_count got=%0d exp=1", got_sb.size()); end
      else begin
         total++; if (got_sb[0] !== 31) begin bad++; $display("FAIL sat_sum got=%0d exp=31", got_sb[0]); end
      end
      total++; if (got_s.size() !== 1) begin bad++; $display("FAIL wide_count got=%0d exp=1", got_s.size()); end
      else begin
         total++; if (got_s[0] !== 48) begin bad++; $display("FAIL wide_sum got=%0d exp=48", got_s[0]); end
      end
      tick();
      total++; if (sat_flag_b !== 1'b1) begin bad++; $display("FAIL sat_flag_sticky got=%0d exp=1", sat_flag_b); end
      total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL wide_sat_flag got=%0d exp=0", sat_flag); end
   endtask

   task automatic test_enable_low();
      enable = 1'b0;
      in_valid = 1'b1; in_neuron = 4'd7; in_score = 5'd9; window_done = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL en_in_ready got=%0d exp=0", in_ready); end
      tick();
      in_valid = 1'b0; window_done = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_window_ignored got=%0d exp=0", busy); end
      enable = 1'b1;
      pulse_done();
      drain_collect(cyc);
      total++; if (got_n.size() !== 0) begin bad++; $display("FAIL en_no_accept got=%0d exp=0", got_n.size()); end
      tick();
   endtask

   task automatic test_rst_mid_drain();
      int guard = 0;
      hit(1, 6); hit(5, 2);
      pulse_done();
      while (!(out_valid && out_ready) && guard < 50) begin tick(); guard++; end
      total++; if (guard >= 50) begin bad++; $display("FAIL rst_first_out got=timeout exp=valid"); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0d exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
      pulse_done();
      drain_collect(cyc);
      total++; if (got_n.size() !== 0) begin bad++; $display("FAIL rst_sums_lost got=%0d exp=0", got_n.size()); end
      total++; if (cyc !== 17) begin bad++; $display("FAIL rst_next_cycles got=%0d exp=17", cyc); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_neuron();
      test_order();
      test_same_cycle();
      test_stall();
      test_saturation();
      test_enable_low();
      test_rst_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
